bist_sequencer: RTL and testbench

BIST_SEQUENCER -- requirements
Module: bist_sequencer

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_lfsr_gen.sv | 37 +++
 rtl/bist_sequencer.sv | 136 +++++++++++++
 tb/tb_bist_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST sequencer slice.
package bist_pkg;

  // Sequencer states; explicit values keep the legacy encoding visible.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  // Default pattern generator: x^8+x^6+x^5+x^4+1 style tap mask, seed 1.
  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_LFSR_SEED = 8'h01;

  // Default signature polynomial x^5+x^2+1 (the x^5 term is implicit).
  localparam logic [4:0] DEF_MISR_POLY = 5'h05;

endpackage

// File: rtl/bist_lfsr_gen.sv
// Fibonacci-style LFSR pattern generator with synchronous load and enable.
module bist_lfsr_gen
  import bist_pkg::*;
#(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] SEED      = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  output logic [LFSR_W-1:0] pattern
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic fb;

  // Feedback bit is the parity of the tapped pattern bits.
  always_comb begin
    fb = ^(pattern & LFSR_TAPS);
  end

  // Load takes priority over stepping; reset returns to the seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= SEED_EFF;
    end else if (load) begin
      pattern <= SEED_EFF;
    end else if (enable) begin
      pattern <= {pattern[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: drives LFSR patterns into a circuit under test, compacts
// the responses in a MISR and compares the signature with a golden value.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] SEED      = DEF_LFSR_SEED,
  parameter int                MISR_W    = 5,
  parameter logic [MISR_W-1:0] MISR_POLY = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0] MISR_INIT = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  test_cycles,
  input  logic [MISR_W-1:0] golden,
  input  logic [MISR_W-1:0] cut_resp,
  output logic [LFSR_W-1:0] pattern,
  output logic              pattern_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bist_state_e       state;
  logic [CNT_W-1:0]  tc_q;
  logic [MISR_W-1:0] golden_q;
  logic              in_load;
  logic              in_run;
  logic              in_compare;
  logic              lfsr_load;
  logic              last_run;

  // Decode state and derive datapath strobes; abort suppresses any update.
  always_comb begin
    in_load       = (state == ST_LOAD);
    in_run        = (state == ST_RUN);
    in_compare    = (state == ST_COMPARE);
    busy          = in_load | in_run | in_compare;
    pattern_valid = in_run & ~abort;
    lfsr_load     = in_load & ~abort;
    // Only evaluated in RUN, where tc_q is known to be non-zero.
    last_run      = (cycle_count == (tc_q - CNT_ONE));
  end

  bist_lfsr_gen #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .SEED      (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .enable  (pattern_valid),
    .pattern (pattern)
  );

  // MISR: shift with polynomial feedback and fold in the CUT response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signature <= MISR_INIT;
    end else if (lfsr_load) begin
      signature <= MISR_INIT;
    end else if (pattern_valid) begin
      signature <= {signature[MISR_W-2:0], 1'b0}
                 ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                 ^ cut_resp;
    end
  end

  // Sequencer FSM with latched test parameters, counter and result flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tc_q        <= '0;
      golden_q    <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            state    <= ST_LOAD;
            tc_q     <= test_cycles;
            golden_q <= golden;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            cycle_count <= '0;
            state       <= (tc_q == '0) ? ST_COMPARE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            cycle_count <= cycle_count + CNT_ONE;
            if (last_run) begin
              state <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            pass  <= (signature == golden_q);
            fail  <= (signature != golden_q);
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer with a transaction-level model.
module tb_bist_sequencer;

  localparam int         CW     = 16;
  localparam logic [7:0] TAPS   = 8'hB8;
  localparam logic [7:0] SEEDV  = 8'h01;
  localparam logic [5:0] POLY_F = 6'h25;  // x^5 + x^2 + 1 including top term

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] test_cycles = '0;
  logic [4:0]    golden = '0;
  logic [4:0]    cut_resp = '0;

  logic [7:0]    pattern;
  logic          pattern_valid;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic [4:0]    signature;
  logic [CW-1:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bist_sequencer #(
    .LFSR_W    (8),
    .LFSR_TAPS (8'hB8),
    .SEED      (8'h01),
    .MISR_W    (5),
    .MISR_POLY (5'h05),
    .MISR_INIT (5'h00),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .test_cycles   (test_cycles),
    .golden        (golden),
    .cut_resp      (cut_resp),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .signature     (signature),
    .cycle_count   (cycle_count)
  );

  // Reference arithmetic
  function automatic logic [7:0] m_lfsr(input logic [7:0] p);
    int ones = $countones(p & TAPS);
    return {p[6:0], 1'(ones % 2)};
  endfunction

  // Signature = signature * x mod poly, plus response
  function automatic logic [4:0] m_misr(input logic [4:0] s, input logic [4:0] r);
    logic [5:0] t = {s, 1'b0};
    if (t[5]) t = t ^ POLY_F;
    return t[4:0] ^ r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a test is a run of cycles counted from the accepted start.
  // k==0 is the load cycle, k in 1..tc applies patterns, k==tc+1 compares.
  bit         m_active, m_done, m_pass, m_fail;
  int         m_k, m_tc;
  logic [7:0] m_pat;
  logic [4:0] m_sig, m_golden;
  logic [CW-1:0] m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_done = 0; m_pass = 0; m_fail = 0;
      m_k = 0; m_tc = 0; m_pat = SEEDV; m_sig = '0; m_golden = '0; m_cnt = '0;
    end else if (m_active) begin
      if (abort) begin
        m_active = 0;
      end else if (m_k == 0) begin
        m_pat = SEEDV; m_sig = '0; m_cnt = '0; m_k = 1;
      end else if (m_k <= m_tc) begin
        m_sig = m_misr(m_sig, cut_resp);
        m_pat = m_lfsr(m_pat);
        m_cnt = m_cnt + 1'b1;
        m_k++;
      end else begin
        m_pass = (m_sig == m_golden);
        m_fail = !m_pass;
        m_done = 1;
        m_active = 0;
      end
    end else if (start && !abort) begin
      m_active = 1; m_k = 0; m_tc = int'(test_cycles); m_golden = golden;
      m_done = 0; m_pass = 0; m_fail = 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("pattern", pattern, m_pat);
    check("pattern_valid", pattern_valid, m_active && m_k >= 1 && m_k <= m_tc && !abort);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("pass", pass, m_pass);
    check("fail", fail, m_fail);
    check("signature", signature, m_sig);
    check("cycle_count", cycle_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int tc, input logic [4:0] g);
    start = 1'b1; test_cycles = CW'(tc); golden = g;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", done, 1'b1);
  endtask

  // Random responses; golden chosen from a precomputed signature.
  task automatic run_rand(input int tc, input bit want_pass);
    logic [4:0] resp [$];
    logic [4:0] s = '0;
    logic [4:0] r;
    logic [4:0] g;
    for (int i = 0; i < tc; i++) begin
      r = 5'($urandom);
      resp.push_back(r);
      s = m_misr(s, r);
    end
    g = want_pass ? s : (s ^ 5'($urandom_range(1, 31)));
    do_start(tc, g);
    test_cycles = 16'($urandom);
    golden = 5'($urandom);
    tick();
    for (int i = 0; i < tc; i++) begin
      cut_resp = resp[i];
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(4);
    check("rand_pass", pass, want_pass);
    check("rand_fail", fail, !want_pass);
    check("rand_signature", signature, s);
    check("rand_cycle_count", cycle_count, CW'(tc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp27 [4];
    logic [7:0] p;
    exp27 = '{8'h01, 8'h02, 8'h04, 8'h08};

    // Reset values
    tick();
    check("rst_pattern", pattern, 8'h01);
    check("rst_signature", signature, 5'h00);
    check("rst_cycle_count", cycle_count, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", pattern_valid, 1'b0);
    rst = 1'b1;
    tick();

    // Model pin: default taps give a period of 255
    p = 8'h01;
    for (int i = 0; i < 255; i++) p = m_lfsr(p);
    check("model_lfsr_period", p, 8'h01);
    check("model_misr_step", m_misr(5'h10, 5'h10), 5'h15);

    // Four patterns from the seed
    do_start(4, 5'h00);
    check("load_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("run_pattern", pattern, exp27[i]);
      check("run_valid", pattern_valid, 1'b1);
      cut_resp = 5'($urandom);
      tick();
    end
    check("pattern_after_run", pattern, 8'h11);
    check("count_after_run", cycle_count, 16'd4);
    tick();
    check("done_after_run", done, 1'b1);

    // Zero-length test
    do_start(0, 5'h00);
    check("zero_load_valid", pattern_valid, 1'b0);
    tick();
    check("zero_cmp_busy", busy, 1'b1);
    check("zero_cmp_valid", pattern_valid, 1'b0);
    tick();
    check("zero_done", done, 1'b1);
    check("zero_pass", pass, 1'b1);
    check("zero_count", cycle_count, 16'd0);

    // Fixed response, pass then fail
    for (int j = 0; j < 2; j++) begin
      cut_resp = 5'h10;
      do_start(2, (j == 0) ? 5'h15 : 5'h14);
      repeat (4) tick();
      check("fixed_signature", signature, 5'h15);
      check("fixed_pass", pass, j == 0);
      check("fixed_fail", fail, j == 1);
    end

    // Abort on the third RUN cycle; start while busy is ignored
    do_start(10, 5'h00);
    tick();
    start = 1'b1; test_cycles = 16'd3; golden = 5'h1F;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1; start = 1'b1;
    #1 check("abort_valid", pattern_valid, 1'b0);
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_count", cycle_count, 16'd2);
    check("abort_pattern", pattern, 8'h04);
    // Abort beats start in IDLE
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_priority_busy", busy, 1'b0);

    // Reset mid-RUN
    do_start(20, 5'h00);
    tick();
    repeat (5) begin
      cut_resp = 5'($urandom);
      tick();
    end
    #1 rst = 1'b0;
    #1;
    check("midrst_pattern", pattern, 8'h01);
    check("midrst_signature", signature, 5'h00);
    check("midrst_count", cycle_count, 16'd0);
    check("midrst_valid", pattern_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_pass", pass, 1'b0);
    check("midrst_fail", fail, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("postrst_done", done, 1'b0);
    run_rand(7, 1'b1);

    // Randomized complete tests
    for (int t = 0; t < 8; t++) begin
      run_rand($urandom_range(1, 40), 1'($urandom));
    end

    // Full LFSR period
    run_rand(255, 1'b1);
    check("period_pattern", pattern, 8'h01);

    // Random soak of start/abort/inputs, model checks every cycle
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 19) == 0);
      test_cycles = 16'($urandom_range(0, 11));
      golden = 5'($urandom);
      cut_resp = 5'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) tick();
    check("soak_settled", busy, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
